tnoc_credit_tx: RTL
===================

# tnoc_credit_tx

Credit-based link transmitter that drains a local flit FIFO and drives a point-to-point link whose far end is a receive FIFO of known depth. It pops a word only when the FIFO is non-empty and a downstream credit is held, registers the word onto the link, and replenishes credits from single-cycle credit-return pulses sent by the receiver as it pops. It sits at every router output port, between the output FIFO and the physical link.

## Interface
- WIDTH, 8, flit/data width in bits
- CREDITS, 8, depth of the downstream receive FIFO; initial and maximum credit count; must be ≥1
- CW (localparam), $clog2(CREDITS+1), credit counter width
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- i_clear  input  1  synchronous clear of link state (credits reload, output idles)
- i_empty  input  1  source FIFO empty flag
- o_pop  output  1  pop strobe to source FIFO (combinational)
- i_data  input  WIDTH  source FIFO head word; valid when i_empty=0
- o_valid  output  1  link flit valid, registered, one cycle per flit
- o_data  output  WIDTH  link flit data, registered
- i_credit_return  input  1  one credit returned per high cycle
- o_credit_count  output  CW  current credits held
- o_credit_error  output  1  sticky: credit returned while counter already at CREDITS

## Operation
- Reset values: o_valid=0, o_data=0, o_credit_count=CREDITS, o_credit_error=0; o_pop=0 while rst_n low.
- send = !i_empty && (o_credit_count != 0) && !i_clear; o_pop = send.
- On send: o_data <= i_data, o_valid <= 1. Without send: o_valid <= 0, o_data holds last value.
- Credit update, priority order:
  - i_clear: count <= CREDITS, error <= 0, o_valid <= 0; any i_credit_return in that cycle is discarded.
  - send && i_credit_return: count unchanged.
  - send only: count <= count−1.
  - i_credit_return only: if count == CREDITS, count stays CREDITS and o_credit_error <= 1; else count <= count+1.
- Counter never wraps: 0 is blocked by send gating, CREDITS saturates.
- o_credit_error clears only on reset or i_clear.
- No state machine beyond counter/output register; block is stateless with respect to packet boundaries (flit framing lives in i_data).

## Timing
- Pop-to-link latency 1 cycle: o_pop high in cycle N → o_valid/o_data valid in cycle N+1.
- Full throughput: one flit per cycle while FIFO non-empty and credits > 0.
- With CREDITS credits and link round trip R cycles, sustained throughput is min(1, CREDITS/R); no other stalls.
- Credit returned in cycle N is usable for a send in cycle N+1 (counter is registered; send uses registered count).
- count=1, send and return same cycle → count stays 1, next cycle may send again.
- count=0 and return in cycle N → o_pop low in N, may be high in N+1.
- Reset asserted mid-transfer: o_valid drops immediately (async), credits reload; in-flight receiver state is not the block's concern.
- i_clear and send never coincide (send gated by i_clear).

## Test plan
- Reset/idle: CREDITS=4, release rst_n, i_empty=1 → o_valid=0, o_credit_count=4, o_pop=0 for 10 cycles, o_credit_error=0.
- Credit exhaustion: CREDITS=4, FIFO holds 6 words 0x10..0x15, no returns → o_pop high 4 consecutive cycles, link carries 0x10..0x13 back-to-back starting 1 cycle after first pop, count reaches 0, o_pop stays low.
- Replenish: continue previous; pulse i_credit_return once → next cycle o_pop=1, following cycle o_data=0x14, count returns to 0.
- Simultaneous: count=1, FIFO non-empty, i_credit_return high every cycle → o_pop high every cycle, count stays 1, one flit per cycle, no error.
- Overflow: count=CREDITS=4, i_empty=1, one i_credit_return pulse → count stays 4, o_credit_error=1 and remains 1 until i_clear; i_clear → error=0, count=4.
- Clear mid-stream: count=2, FIFO non-empty, assert i_clear one cycle with i_credit_return=1 → o_pop=0 that cycle, next cycle o_valid=0 and count=4, no error; streaming resumes the following cycle.

Source files
------------

// File: rtl/tnoc_credit_tx.sv
// -----------------------------------------------------------------------------
// tnoc_credit_tx
//
// Credit-based link transmitter. Drains a local flit FIFO onto a registered
// point-to-point link whose far end is a receive FIFO of CREDITS entries.
// A flit is popped only when the source FIFO is non-empty and at least one
// downstream credit is held; the receiver hands credits back with
// single-cycle pulses on i_credit_return as it pops its own FIFO.
//
// Handshake semantics:
//   Source side: o_pop is a combinational strobe. While o_pop is high the
//   word on i_data is consumed at the next rising edge (a show-ahead FIFO
//   presents its head word whenever i_empty is low).
//   Link side: there is no ready signal. o_valid is high for exactly one
//   cycle per flit and the receiver must accept it; credits guarantee it
//   has room.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_clear           synchronous clear: credits reload, error clears, link idles
//   i_empty           source FIFO empty flag
//   i_data            source FIFO head word (valid while i_empty is low)
//   o_pop             pop strobe to the source FIFO
//   o_valid, o_data   registered link flit
//   i_credit_return   one credit returned per high cycle
//   o_credit_count    credits currently held
//   o_credit_error    sticky: a credit came back while the counter was full
// -----------------------------------------------------------------------------
module tnoc_credit_tx #(
  parameter int WIDTH   = 8,
  parameter int CREDITS = 8,
  localparam int CW     = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_empty,
  output logic             o_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_credit_return,
  output logic [CW-1:0]    o_credit_count,
  output logic             o_credit_error
);

  localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] ONE         = CW'(1);

  logic          send;
  logic [CW-1:0] count_q;
  logic          error_q;
  logic          valid_q;
  logic [WIDTH-1:0] data_q;

  // The send decision uses the registered count, so a credit returned in
  // cycle N is first spendable in cycle N+1. rst_n gates the pop so the
  // source FIFO is never drained while the block is held in reset.
  always_comb begin
    send = rst_n && !i_empty && (count_q != '0) && !i_clear;
  end

  assign o_pop = send;

  // Link output register: data holds its last value when idle so the link
  // does not toggle needlessly between flits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (i_clear) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= send;
      if (send) begin
        data_q <= i_data;
      end
    end
  end

  // Credit counter. A send and a return in the same cycle cancel out.
  // The counter cannot underflow because send is gated on a non-zero count,
  // and it saturates at CREDITS: an extra return there flags the receiver
  // as misbehaving instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= CREDITS_MAX;
      error_q <= 1'b0;
    end else if (i_clear) begin
      count_q <= CREDITS_MAX;
      error_q <= 1'b0;
    end else begin
      unique case ({send, i_credit_return})
        2'b10: count_q <= count_q - ONE;
        2'b01: begin
          if (count_q == CREDITS_MAX) begin
            error_q <= 1'b1;
          end else begin
            count_q <= count_q + ONE;
          end
        end
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_valid        = valid_q;
  assign o_data         = data_q;
  assign o_credit_count = count_q;
  assign o_credit_error = error_q;

endmodule
